decode_execute_stage: RTL and testbench
=======================================

# decode_execute_stage

Decode half and D/E pipeline register of the Execute-stage ALU interface. Turns the Decode-stage instruction word into the 3-bit ALU operation encoding plus datapath controls, registers them with operands into the Execute stage, and owns load-use stall and branch flush sequencing. It produces `SrcAE`, `SrcBE`, `ALUctrlE` and their companions for the ALU one cycle after an instruction is presented in Decode.

## Interface
- `DATA_WIDTH`, 32: operand, immediate and PC width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `InstrD` in 32: instruction in Decode.
- `validD` in 1: `InstrD` holds a real instruction.
- `PCD`, `RD1D`, `RD2D`, `ImmExtD` in `DATA_WIDTH`: Decode PC, register-file reads, extended immediate.
- `PCSrcE` in 1: branch/jump taken in Execute; flushes.
- `SrcAE` out `DATA_WIDTH`: registered `RD1D`, or 0 for LUI.
- `SrcBE` out `DATA_WIDTH`: registered `RD2D` or `ImmExtD`, selected by ALUSrc.
- `WriteDataE`, `PCE`, `ImmExtE` out `DATA_WIDTH`: registered store data, PC, immediate.
- `ALUctrlE` out 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 pass-B, 110 sll, 111 srl.
- `Rs1E`, `Rs2E`, `RdE` out 5: register indices.
- `RegWriteE`, `MemWriteE`, `BranchE`, `JumpE`, `validE` out 1: Execute controls.
- `ResultSrcE` out 2: 00 ALU, 01 memory, 10 PC+4.
- `StallD` out 1: hold Fetch/Decode registers this cycle.
- `illegalE` out 1: one-cycle flag, see Configuration.

## Operation
- Supported opcodes:
  - R-type 0110011, I-ALU 0010011.
  - Load 0000011, store 0100011: add, ALUSrc=1.
  - Branch 1100011: sub, BranchE=1; funct3 001 (bne) only.
  - LUI 0110111: pass-B, ALUSrc=1.
  - JAL 1101111: JumpE=1, ResultSrc=10.
- funct3 mapping: 000 add (sub when R-type and funct7[5]=1), 111 and, 110 or, 100 xor, 001 sll, 101 srl with funct7[5]=0. funct7[5]=1 with funct3 101 (sra) is unsupported.
- FSM states:
  - RUN → LDSTALL when a valid load in E has `RdE`≠0 and `RdE` equals a source register used by the instruction in D. Rs2 counts as used only for R-type, store and branch.
  - LDSTALL → RUN unconditionally after one cycle.
- RUN with hazard: `StallD`=1 (combinational) and a bubble is loaded into E.
- Bubble: validE, RegWriteE, MemWriteE, BranchE, JumpE, illegalE all 0. All other E fields are 0.
- `PCSrcE`=1 loads a bubble next edge and clears `StallD`, which overrides a coincident hazard. FSM returns to RUN.
- `validD`=0 loads a bubble.

## Timing
- Latency 1 cycle: D fields sampled at edge n appear on E outputs after edge n.
- Load-use costs exactly one bubble. The dependent instruction enters E on the second edge.
- Reset, including mid-stall: every output 0, FSM=RUN, `StallD`=0 while `rst_n` is low and after release.
- No back-to-back stall for the same instruction: the E stage holds a bubble in LDSTALL.

## Configuration
- `DEC_EXE_ILLEGAL_DETECT_EN` defined: unsupported opcode/funct combinations load a bubble with `illegalE`=1 for one cycle.
- Undefined: unsupported encodings decode as add with decoded-opcode controls. `illegalE` is tied 0.

## Structure
- Package `alu_pkg`: ALU op enum (the 3-bit encoding above), opcode constants, ResultSrc encoding, FSM state enum.
- Sub-module `alu_decoder`: combinational opcode/funct3/funct7 → control bundle and illegal flag. The top holds the FSM, hazard compare and D/E register.

## Test plan
- `InstrD`=0x402081B3 (sub x3,x1,x2), `RD1D`=9, `RD2D`=4 → next cycle `ALUctrlE`=001, `SrcAE`=9, `SrcBE`=4, `RdE`=3, `RegWriteE`=1.
- `InstrD`=0x123452B7 (lui x5), `ImmExtD`=0x12345000 → `ALUctrlE`=101, `SrcBE`=0x12345000, `RdE`=5.
- 0x0000A203 (lw x4) then 0x00220333 (add x6,x4,x2) → `StallD`=1 for one cycle, one bubble, add in E two edges after lw.
- Load-use hazard with `PCSrcE`=1 in the same cycle → `StallD`=0, bubble in E, FSM RUN.
- 0x4020D1B3 (sra) with macro → bubble, `illegalE`=1 one cycle. Without macro → `ALUctrlE`=000, `RegWriteE`=1.
- `rst_n` low during LDSTALL → all outputs 0 immediately. After release, lw/add sequence runs as above.

Source files
------------

// File: rtl/decode_execute_stage_pkg.sv
// Shared types for the decode/execute boundary: ALU op encoding, opcodes, result select, FSM states.
// Also holds the funct3/funct7 helpers used by the decoder.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_PASSB = 3'b101,
        ALU_SLL   = 3'b110,
        ALU_SRL   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LDSTALL = 1'b1
    } stage_state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        src_a_zero;
        logic        use_rs2;
        result_src_e result_src;
        alu_op_e     alu_op;
    } ctrl_t;

    function automatic alu_op_e arith_op(input logic [2:0] funct3, input logic sub_sel);
        case (funct3)
            F3_ADD:  return sub_sel ? ALU_SUB : ALU_ADD;
            F3_AND:  return ALU_AND;
            F3_OR:   return ALU_OR;
            F3_XOR:  return ALU_XOR;
            F3_SLL:  return ALU_SLL;
            F3_SR:   return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    // True when the funct3/funct7 pair maps onto one of the eight ALU operations.
    function automatic logic arith_supported(input logic [2:0] funct3, input logic funct7_b5);
        case (funct3)
            F3_ADD, F3_AND, F3_OR, F3_XOR, F3_SLL: return 1'b1;
            F3_SR:   return !funct7_b5;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_execute_stage_if.sv
// Decode-side inputs and Execute-side outputs of the D/E stage.
// master drives the Decode fields and flush; slave is the stage itself.
interface decode_execute_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           InstrD;
    logic                  validD;
    logic [DATA_WIDTH-1:0] PCD;
    logic [DATA_WIDTH-1:0] RD1D;
    logic [DATA_WIDTH-1:0] RD2D;
    logic [DATA_WIDTH-1:0] ImmExtD;
    logic                  PCSrcE;

    logic [DATA_WIDTH-1:0] SrcAE;
    logic [DATA_WIDTH-1:0] SrcBE;
    logic [DATA_WIDTH-1:0] WriteDataE;
    logic [DATA_WIDTH-1:0] PCE;
    logic [DATA_WIDTH-1:0] ImmExtE;
    logic [2:0]            ALUctrlE;
    logic [4:0]            Rs1E;
    logic [4:0]            Rs2E;
    logic [4:0]            RdE;
    logic                  RegWriteE;
    logic                  MemWriteE;
    logic                  BranchE;
    logic                  JumpE;
    logic                  validE;
    logic [1:0]            ResultSrcE;
    logic                  StallD;
    logic                  illegalE;

    modport master (
        output InstrD, validD, PCD, RD1D, RD2D, ImmExtD, PCSrcE,
        input  SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUctrlE, Rs1E, Rs2E, RdE,
        input  RegWriteE, MemWriteE, BranchE, JumpE, validE, ResultSrcE, StallD, illegalE
    );

    modport slave (
        input  InstrD, validD, PCD, RD1D, RD2D, ImmExtD, PCSrcE,
        output SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUctrlE, Rs1E, Rs2E, RdE,
        output RegWriteE, MemWriteE, BranchE, JumpE, validE, ResultSrcE, StallD, illegalE
    );

endinterface

// File: rtl/decode_execute_stage_alu_decoder.sv
// Combinational instruction decoder: opcode/funct3/funct7 to control bundle and illegal flag.
// Build option: DEC_EXE_ILLEGAL_DETECT_EN exposes the illegal flag; otherwise it is tied low.
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic        illegal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unsupported;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7_b5     = instr[30];
    assign unused_fields = &{1'b0, instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        ctrl            = '0;
        ctrl.alu_op     = ALU_ADD;
        ctrl.result_src = RES_ALU;
        unsupported     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.use_rs2   = 1'b1;
                ctrl.alu_op    = arith_op(funct3, funct7_b5);
                unsupported    = !arith_supported(funct3, funct7_b5);
            end
            OP_IALU: begin
                // Bit 30 is immediate data here, so addi never becomes a subtract.
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = arith_op(funct3, 1'b0);
                unsupported    = !arith_supported(funct3, funct7_b5);
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.use_rs2   = 1'b1;
            end
            OP_BRANCH: begin
                ctrl.branch  = 1'b1;
                ctrl.use_rs2 = 1'b1;
                ctrl.alu_op  = ALU_SUB;
                unsupported  = (funct3 != F3_BNE);
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.src_a_zero = 1'b1;
                ctrl.alu_op     = ALU_PASSB;
            end
            OP_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            default: unsupported = 1'b1;
        endcase
        if (unsupported) begin
            ctrl.alu_op = ALU_ADD;
        end
    end

`ifdef DEC_EXE_ILLEGAL_DETECT_EN
    assign illegal = unsupported;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/decode_execute_stage.sv
// D/E pipeline register with load-use stall FSM and branch flush, feeding the Execute-stage ALU.
// Build option: DEC_EXE_ILLEGAL_DETECT_EN turns unsupported encodings into flagged bubbles.
module decode_execute_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decode_execute_stage_if.slave bus
);
    localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

    ctrl_t        dec_ctrl;
    logic         dec_illegal;
    logic [4:0]   rs1_d;
    logic [4:0]   rs2_d;
    logic [4:0]   rd_d;
    stage_state_e state;
    logic         load_in_e;
    logic         hazard;
    logic         bubble;
    logic         illegal_flag;

    alu_decoder u_alu_decoder (
        .instr   (bus.InstrD),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign rs1_d = bus.InstrD[19:15];
    assign rs2_d = bus.InstrD[24:20];
    assign rd_d  = bus.InstrD[11:7];

    // Only loads select the memory result, so that alone identifies a load sitting in E.
    assign load_in_e = bus.validE && (bus.ResultSrcE == RES_MEM);
    assign hazard    = (state == ST_RUN) && bus.validD && load_in_e && (bus.RdE != 5'd0)
                       && ((rs1_d == bus.RdE) || (dec_ctrl.use_rs2 && (rs2_d == bus.RdE)));

    // A taken branch discards the dependent instruction anyway, so it cancels the stall.
    assign bus.StallD   = hazard && !bus.PCSrcE;
    assign bubble       = bus.PCSrcE || bus.StallD || !bus.validD || dec_illegal;
    assign illegal_flag = dec_illegal && bus.validD && !bus.PCSrcE && !bus.StallD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            bus.SrcAE      <= '0;
            bus.SrcBE      <= '0;
            bus.WriteDataE <= '0;
            bus.PCE        <= '0;
            bus.ImmExtE    <= '0;
            bus.ALUctrlE   <= '0;
            bus.Rs1E       <= '0;
            bus.Rs2E       <= '0;
            bus.RdE        <= '0;
            bus.RegWriteE  <= 1'b0;
            bus.MemWriteE  <= 1'b0;
            bus.BranchE    <= 1'b0;
            bus.JumpE      <= 1'b0;
            bus.validE     <= 1'b0;
            bus.ResultSrcE <= '0;
            bus.illegalE   <= 1'b0;
        end else begin
            case (state)
                ST_RUN:  state <= bus.StallD ? ST_LDSTALL : ST_RUN;
                default: state <= ST_RUN;
            endcase
            bus.illegalE <= illegal_flag;
            if (bubble) begin
                bus.SrcAE      <= '0;
                bus.SrcBE      <= '0;
                bus.WriteDataE <= '0;
                bus.PCE        <= '0;
                bus.ImmExtE    <= '0;
                bus.ALUctrlE   <= '0;
                bus.Rs1E       <= '0;
                bus.Rs2E       <= '0;
                bus.RdE        <= '0;
                bus.RegWriteE  <= 1'b0;
                bus.MemWriteE  <= 1'b0;
                bus.BranchE    <= 1'b0;
                bus.JumpE      <= 1'b0;
                bus.validE     <= 1'b0;
                bus.ResultSrcE <= '0;
            end else begin
                bus.SrcAE      <= dec_ctrl.src_a_zero ? ZERO_WORD : bus.RD1D;
                bus.SrcBE      <= dec_ctrl.alu_src ? bus.ImmExtD : bus.RD2D;
                bus.WriteDataE <= bus.RD2D;
                bus.PCE        <= bus.PCD;
                bus.ImmExtE    <= bus.ImmExtD;
                bus.ALUctrlE   <= dec_ctrl.alu_op;
                bus.Rs1E       <= rs1_d;
                bus.Rs2E       <= rs2_d;
                bus.RdE        <= rd_d;
                bus.RegWriteE  <= dec_ctrl.reg_write;
                bus.MemWriteE  <= dec_ctrl.mem_write;
                bus.BranchE    <= dec_ctrl.branch;
                bus.JumpE      <= dec_ctrl.jump;
                bus.validE     <= 1'b1;
                bus.ResultSrcE <= dec_ctrl.result_src;
            end
        end
    end

endmodule

// File: tb/tb_decode_execute_stage.sv
// Self-checking bench for decode_execute_stage: decode table, load-use/flush/reset sequences,
// and a randomized run against a rule-level reference model.
module tb_decode_execute_stage;
    localparam int DW = 32;

`ifdef DEC_EXE_ILLEGAL_DETECT_EN
    localparam bit DETECT = 1'b1;
`else
    localparam bit DETECT = 1'b0;
`endif

    localparam logic [31:0] I_LW  = 32'h0000A203;
    localparam logic [31:0] I_ADD = 32'h00220333;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    decode_execute_stage_if #(.DATA_WIDTH(DW)) bus ();
    decode_execute_stage #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] srca, srcb, wdata, pc, imm;
        logic [2:0]  alu;
        logic [4:0]  rs1, rs2, rd;
        logic        regw, memw, branch, jump, valid;
        logic [1:0]  rsrc;
        logic        illegal;
    } e_t;

    typedef struct packed {
        logic [2:0]  alu;
        logic [31:0] srca, srcb;
        logic [4:0]  rd;
        logic        regw, memw, branch, jump, valid;
        logic [1:0]  rsrc;
        logic        illegal;
    } view_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] rd1, rd2, imm;
        view_t       exp;
    } vec_t;

    function automatic e_t get_e();
        e_t e;
        e.srca = bus.SrcAE; e.srcb = bus.SrcBE; e.wdata = bus.WriteDataE;
        e.pc = bus.PCE; e.imm = bus.ImmExtE; e.alu = bus.ALUctrlE;
        e.rs1 = bus.Rs1E; e.rs2 = bus.Rs2E; e.rd = bus.RdE;
        e.regw = bus.RegWriteE; e.memw = bus.MemWriteE; e.branch = bus.BranchE;
        e.jump = bus.JumpE; e.valid = bus.validE; e.rsrc = bus.ResultSrcE;
        e.illegal = bus.illegalE;
        return e;
    endfunction

    function automatic view_t get_view();
        view_t v;
        v.alu = bus.ALUctrlE; v.srca = bus.SrcAE; v.srcb = bus.SrcBE; v.rd = bus.RdE;
        v.regw = bus.RegWriteE; v.memw = bus.MemWriteE; v.branch = bus.BranchE;
        v.jump = bus.JumpE; v.valid = bus.validE; v.rsrc = bus.ResultSrcE;
        v.illegal = bus.illegalE;
        return v;
    endfunction

    function automatic view_t mk(input logic [2:0] alu, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic regw, input logic memw,
                                 input logic br, input logic jmp, input logic [1:0] rsrc);
        view_t v;
        v.alu = alu; v.srca = a; v.srcb = b; v.rd = rd; v.regw = regw; v.memw = memw;
        v.branch = br; v.jump = jmp; v.valid = 1'b1; v.rsrc = rsrc; v.illegal = 1'b0;
        return v;
    endfunction

    // Reference: what the Execute stage should hold for an instruction, from the ISA rules.
    function automatic e_t ref_e(input logic [31:0] ins, input logic v, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        e_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic b30, bad, imm_sel;
        e = '0; op = ins[6:0]; f3 = ins[14:12]; b30 = ins[30]; bad = 1'b0; imm_sel = 1'b0;
        if (!v) return e;
        case (op)
            7'h33, 7'h13: begin
                e.regw = 1'b1;
                imm_sel = (op == 7'h13);
                case (f3)
                    3'd0: e.alu = (op == 7'h33 && b30) ? 3'd1 : 3'd0;
                    3'd7: e.alu = 3'd2;
                    3'd6: e.alu = 3'd3;
                    3'd4: e.alu = 3'd4;
                    3'd1: e.alu = 3'd6;
                    3'd5: if (b30) bad = 1'b1; else e.alu = 3'd7;
                    default: bad = 1'b1;
                endcase
            end
            7'h03: begin e.regw = 1'b1; imm_sel = 1'b1; e.rsrc = 2'b01; end
            7'h23: begin e.memw = 1'b1; imm_sel = 1'b1; end
            7'h63: begin e.branch = 1'b1; if (f3 == 3'd1) e.alu = 3'd1; else bad = 1'b1; end
            7'h37: begin e.regw = 1'b1; imm_sel = 1'b1; e.alu = 3'd5; end
            7'h6f: begin e.regw = 1'b1; e.jump = 1'b1; imm_sel = 1'b1; e.rsrc = 2'b10; end
            default: bad = 1'b1;
        endcase
        if (bad && DETECT) begin
            e = '0;
            e.illegal = 1'b1;
            return e;
        end
        e.valid = 1'b1;
        e.srca = (op == 7'h37) ? 32'd0 : a;
        e.srcb = imm_sel ? imm : b;
        e.wdata = b; e.pc = pc; e.imm = imm;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        return e;
    endfunction

    function automatic logic ref_hazard(input e_t cur, input logic [31:0] ins, input logic v);
        logic reads_rs2;
        reads_rs2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
        return v && cur.valid && (cur.rsrc == 2'b01) && (cur.rd != 5'd0)
               && ((ins[19:15] == cur.rd) || (reads_rs2 && (ins[24:20] == cur.rd)));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic b5;
        rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7)); b5 = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 8))
            0:       return {1'b0, b5, 5'd0, rs2, rs1, f3, rd, 7'h33};
            1:       return {12'($urandom), rs1, f3, rd, 7'h13};
            2, 3:    return {12'($urandom), rs1, 3'b010, rd, 7'h03};
            4:       return {7'd0, rs2, rs1, 3'b010, 5'($urandom), 7'h23};
            5:       return {7'd0, rs2, rs1, {2'b00, b5}, 5'd0, 7'h63};
            6:       return {20'($urandom), rd, 7'h37};
            7:       return {20'($urandom), rd, 7'h6f};
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input logic [31:0] instr, input logic valid, input logic [31:0] pc,
                                 input logic [31:0] rd1, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic pcsrc);
        bus.InstrD = instr; bus.validD = valid; bus.PCD = pc;
        bus.RD1D = rd1; bus.RD2D = rd2; bus.ImmExtD = imm; bus.PCSrcE = pcsrc;
    endtask

    task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // lw x4 followed by a dependent add x6,x4,x2: one stall cycle, one bubble.
    task automatic runLoadUse(input string tag);
        @(negedge clk);
        applyStimulus(I_LW, 1'b1, 32'h100, 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput({tag, " lw in E"}, get_view(), mk(3'd0, 32'h40, 32'h0, 5'd4, 1, 0, 0, 0, 2'b01));
        applyStimulus(I_ADD, 1'b1, 32'h104, 32'd11, 32'd4, 32'h0, 1'b0);
        #1;
        checkOutput({tag, " stall"}, bus.StallD, 1'b1);
        @(negedge clk);
        checkOutput({tag, " bubble"}, get_e(), '0);
        checkOutput({tag, " stall one cycle"}, bus.StallD, 1'b0);
        @(negedge clk);
        checkOutput({tag, " add in E"}, get_view(), mk(3'd0, 32'd11, 32'd4, 5'd6, 1, 0, 0, 0, 2'b00));
        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    vec_t vecs[15];
    view_t ill_v;
    e_t model_e;

    initial begin
        ill_v = '0;
        ill_v.illegal = 1'b1;
        vecs[0]  = '{"sub", 32'h402081B3, 1, 9, 4, 32'h10, mk(3'd1, 9, 4, 5'd3, 1, 0, 0, 0, 2'b00)};
        vecs[1]  = '{"lui", 32'h123452B7, 1, 9, 4, 32'h12345000, mk(3'd5, 0, 32'h12345000, 5'd5, 1, 0, 0, 0, 2'b00)};
        vecs[2]  = '{"and", 32'h0020F3B3, 1, 9, 4, 32'h10, mk(3'd2, 9, 4, 5'd7, 1, 0, 0, 0, 2'b00)};
        vecs[3]  = '{"or", 32'h0020E433, 1, 9, 4, 32'h10, mk(3'd3, 9, 4, 5'd8, 1, 0, 0, 0, 2'b00)};
        vecs[4]  = '{"xor", 32'h0020C4B3, 1, 9, 4, 32'h10, mk(3'd4, 9, 4, 5'd9, 1, 0, 0, 0, 2'b00)};
        vecs[5]  = '{"sll", 32'h00209533, 1, 9, 4, 32'h10, mk(3'd6, 9, 4, 5'd10, 1, 0, 0, 0, 2'b00)};
        vecs[6]  = '{"srl", 32'h0020D5B3, 1, 9, 4, 32'h10, mk(3'd7, 9, 4, 5'd11, 1, 0, 0, 0, 2'b00)};
        vecs[7]  = '{"addi", 32'h00508613, 1, 9, 4, 32'd5, mk(3'd0, 9, 5, 5'd12, 1, 0, 0, 0, 2'b00)};
        vecs[8]  = '{"sw", 32'h0020A423, 1, 9, 4, 32'd8, mk(3'd0, 9, 8, 5'd8, 0, 1, 0, 0, 2'b00)};
        vecs[9]  = '{"bne", 32'h00209063, 1, 9, 4, 32'h10, mk(3'd1, 9, 4, 5'd0, 0, 0, 1, 0, 2'b00)};
        vecs[10] = '{"jal", 32'h000000EF, 1, 9, 4, 32'h20, mk(3'd0, 9, 32'h20, 5'd1, 1, 0, 0, 1, 2'b10)};
        vecs[11] = '{"sra", 32'h4020D1B3, 1, 9, 4, 32'h10,
                     DETECT ? ill_v : mk(3'd0, 9, 4, 5'd3, 1, 0, 0, 0, 2'b00)};
        vecs[12] = '{"bad opcode", 32'h0000007F, 1, 9, 4, 32'h10,
                     DETECT ? ill_v : mk(3'd0, 9, 4, 5'd0, 0, 0, 0, 0, 2'b00)};
        vecs[13] = '{"invalid D", 32'h402081B3, 0, 9, 4, 32'h10, '0};
        vecs[14] = '{"lw", I_LW, 1, 9, 4, 32'h0, mk(3'd0, 9, 0, 5'd4, 1, 0, 0, 0, 2'b01)};

        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        #1;
        checkOutput("reset outputs", get_e(), '0);
        checkOutput("reset StallD", bus.StallD, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            applyStimulus(vecs[i].instr, vecs[i].valid, 32'h200 + 32'(i), vecs[i].rd1, vecs[i].rd2,
                          vecs[i].imm, 1'b0);
            @(negedge clk);
            checkOutput(vecs[i].name, get_view(), vecs[i].exp);
        end
        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);

        runLoadUse("loaduse");

        // Flush coincident with a load-use hazard.
        @(negedge clk);
        applyStimulus(I_LW, 1'b1, 32'h300, 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        applyStimulus(I_ADD, 1'b1, 32'h304, 32'd21, 32'd2, 32'h0, 1'b1);
        #1;
        checkOutput("flush StallD", bus.StallD, 1'b0);
        @(negedge clk);
        checkOutput("flush bubble", get_e(), '0);
        applyStimulus(I_ADD, 1'b1, 32'h304, 32'd21, 32'd2, 32'h0, 1'b0);
        #1;
        checkOutput("after flush StallD", bus.StallD, 1'b0);
        @(negedge clk);
        checkOutput("after flush add", get_view(), mk(3'd0, 32'd21, 32'd2, 5'd6, 1, 0, 0, 0, 2'b00));

        // Reset while the stall is being raised, then again while in LDSTALL.
        applyStimulus(I_LW, 1'b1, 32'h400, 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        applyStimulus(I_ADD, 1'b1, 32'h404, 32'd11, 32'd4, 32'h0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-stall outputs", get_e(), '0);
        checkOutput("reset mid-stall StallD", bus.StallD, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(I_LW, 1'b1, 32'h400, 32'h40, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        applyStimulus(I_ADD, 1'b1, 32'h404, 32'd11, 32'd4, 32'h0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset in LDSTALL outputs", get_e(), '0);
        checkOutput("reset in LDSTALL StallD", bus.StallD, 1'b0);
        applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        runLoadUse("post-reset");

        // Randomized run; stalled instructions stay in D as the real front end would hold them.
        @(negedge clk);
        model_e = '0;
        begin
            logic [31:0] ins, pc, a, b, imm;
            logic v, pcsrc, exp_stall, held;
            held = 1'b0;
            ins = 32'h0; pc = 32'h0; a = 32'h0; b = 32'h0; imm = 32'h0; v = 1'b0;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                checkOutput("random E stage", get_e(), model_e);
                if (!held) begin
                    ins = rand_instr();
                    v = ($urandom_range(0, 9) != 0);
                    pc = $urandom; a = $urandom; b = $urandom; imm = $urandom;
                end
                pcsrc = ($urandom_range(0, 9) == 0);
                applyStimulus(ins, v, pc, a, b, imm, pcsrc);
                #1;
                exp_stall = ref_hazard(model_e, ins, v) && !pcsrc;
                checkOutput("random StallD", bus.StallD, exp_stall);
                model_e = (exp_stall || pcsrc) ? e_t'('0) : ref_e(ins, v, pc, a, b, imm);
                held = exp_stall;
            end
            @(negedge clk);
            checkOutput("random final E stage", get_e(), model_e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
